// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared mode encodings and default parameters for the TRNG word FIFO
package trng_pkg;

    typedef enum logic {
        MODE_RAW = 1'b0,
        MODE_VN  = 1'b1
    } trng_mode_e;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_RCT_LIMIT = 16;

endpackage

// File: rtl/trng_fifo_if.sv
// rtl/trng_fifo_if.sv - consumer-side word stream interface of the TRNG (data, valid, ready, level)
interface trng_fifo_if #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
);
    logic [WORD_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     level;

    modport master (
        output out_data,
        output out_valid,
        output level,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  level,
        output out_ready
    );
endinterface

// File: rtl/trng_word_fifo.sv
// rtl/trng_word_fifo.sv - show-ahead word FIFO with flush, used by trng_fifo
module trng_word_fifo #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;
    // An empty FIFO presents zero rather than a stale entry.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: pointers wrap naturally since DEPTH is a power of two; flush overrides all.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only visible while counted in level, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/trng_fifo.sv
// rtl/trng_fifo.sv - TRNG debias, word assembly, repetition-count health test (TRNG_HEALTH_EN) and word FIFO
module trng_fifo
    import trng_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int RCT_LIMIT = DEF_RCT_LIMIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         raw_bit,
    input  logic         mode,
    output logic         health_fail,
    input  logic         health_clr,
    trng_fifo_if.master  out_if
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic              mode_q, mode_d;
    logic              pair_v_q, pair_v_d;
    logic              pair_b_q, pair_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] part_q, part_d;

    logic              hfail, fail_evt;
    logic              fifo_full, fifo_empty, push_word;
    logic [WORD_W-1:0] push_data;

`ifdef TRNG_HEALTH_EN
    logic [7:0] run_q, run_d;
    logic       last_q, last_d;
    logic       health_fail_q, health_fail_d;
    logic [7:0] run_nx;

    // Repetition count: a run reaching the limit raises a sticky failure, which beats a clear.
    always_comb begin
        run_d         = run_q;
        last_d        = last_q;
        health_fail_d = health_fail_q;
        fail_evt      = 1'b0;
        run_nx        = 8'd1;
        if (enable && !health_fail_q) begin
            if (run_q != 8'd0 && raw_bit == last_q) begin
                run_nx = run_q + 8'd1;
            end
            run_d  = run_nx;
            last_d = raw_bit;
            if (run_nx == 8'(RCT_LIMIT)) begin
                fail_evt      = 1'b1;
                health_fail_d = 1'b1;
            end
        end
        if (health_clr && !fail_evt) begin
            health_fail_d = 1'b0;
            run_d         = 8'd0;
        end
    end

    // Health-test state.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q         <= 8'd0;
            last_q        <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            run_q         <= run_d;
            last_q        <= last_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign hfail = health_fail_q;
`else
    logic unused_health_clr;
    assign unused_health_clr = health_clr;
    assign hfail    = 1'b0;
    assign fail_evt = 1'b0;
`endif

    assign health_fail = hfail;

    // Debias and bit assembly; a mode change or health failure discards in-progress state.
    always_comb begin
        logic accept, emit;
        logic [WORD_W-1:0] word;
        mode_d    = mode;
        pair_v_d  = pair_v_q;
        pair_b_d  = pair_b_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        push_word = 1'b0;
        emit      = 1'b0;
        if (mode != mode_q) begin
            pair_v_d = 1'b0;
            cnt_d    = '0;
            part_d   = '0;
        end
        if (!enable) begin
            pair_v_d = 1'b0;
        end
        accept = enable && !fifo_full && !hfail;
        if (accept) begin
            if (mode == MODE_RAW) begin
                emit = 1'b1;
            end else if (!pair_v_d) begin
                pair_v_d = 1'b1;
                pair_b_d = raw_bit;
            end else begin
                pair_v_d = 1'b0;
                emit     = (pair_b_q != raw_bit);
            end
        end
        word = WORD_W'({part_d, raw_bit});
        push_data = word;
        if (emit) begin
            if (cnt_d == CNT_W'(WORD_W - 1)) begin
                push_word = 1'b1;
                cnt_d     = '0;
                part_d    = '0;
            end else begin
                cnt_d  = cnt_d + 1'b1;
                part_d = word;
            end
        end
        if (fail_evt) begin
            push_word = 1'b0;
            pair_v_d  = 1'b0;
            cnt_d     = '0;
            part_d    = '0;
        end
    end

    // Assembler state; the previous mode is tracked through reset so no false change follows it.
    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        if (rst) begin
            pair_v_q <= 1'b0;
            pair_b_q <= 1'b0;
            cnt_q    <= '0;
            part_q   <= '0;
        end else begin
            pair_v_q <= pair_v_d;
            pair_b_q <= pair_b_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
        end
    end

    trng_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_word),
        .pop   (out_if.out_ready),
        .flush (fail_evt),
        .wdata (push_data),
        .rdata (out_if.out_data),
        .level (out_if.level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_if.out_valid = !fifo_empty;
endmodule

// File: tb/tb_trng_fifo.sv
// tb/tb_trng_fifo.sv - self-checking bench for trng_fifo against a queue-based reference model
module tb_trng_fifo;
    import trng_pkg::*;

    localparam int WORD_W    = 8;
    localparam int DEPTH     = 4;
    localparam int RCT_LIMIT = 16;

    logic clk = 1'b0;
    logic rst, enable, raw_bit, mode, health_clr, health_fail;

    always #5 clk = ~clk;

    trng_fifo_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) out_if ();

    trng_fifo #(
        .WORD_W    (WORD_W),
        .DEPTH     (DEPTH),
        .RCT_LIMIT (RCT_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .raw_bit     (raw_bit),
        .mode        (mode),
        .health_fail (health_fail),
        .health_clr  (health_clr),
        .out_if      (out_if)
    );

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    logic [7:0] m_fifo[$];
    int         m_bits[$];
    int         m_pair = -1;
    bit         m_mode_prev = 1'b0;
    bit         m_fail = 1'b0;
    int         m_run = 0;
    int         m_last = -1;
    int         r_last = -1;
    int         r_same = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_edge(bit r, bit en, bit b, bit md, bit rdy, bit clr);
        bit full, popped, fail_now, accept, emit, do_push;
        logic [7:0] w;
        int run;
        if (r) begin
            m_fifo.delete(); m_bits.delete();
            m_pair = -1; m_fail = 0; m_run = 0; m_last = -1; m_mode_prev = md;
            return;
        end
        full   = (m_fifo.size() == DEPTH);
        popped = rdy && (m_fifo.size() > 0);
        if (md != m_mode_prev) begin
            m_pair = -1;
            m_bits.delete();
        end
        m_mode_prev = md;
        if (!en) m_pair = -1;
        fail_now = 0;
`ifdef TRNG_HEALTH_EN
        if (en && !m_fail) begin
            run = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
            m_run = run;
            m_last = b;
            if (run == RCT_LIMIT) fail_now = 1;
        end
`endif
        accept = en && !full && !m_fail;
        emit = 0;
        if (accept) begin
            if (md == 1'b0) emit = 1;
            else if (m_pair < 0) m_pair = b;
            else begin
                if (m_pair != b) emit = 1;
                m_pair = -1;
            end
        end
        do_push = 0;
        w = 8'h00;
        if (emit) begin
            m_bits.push_back(b);
            if (m_bits.size() == WORD_W) begin
                foreach (m_bits[i]) w = {w[6:0], m_bits[i][0]};
                do_push = 1;
                m_bits.delete();
            end
        end
        if (popped) void'(m_fifo.pop_front());
        if (do_push) m_fifo.push_back(w);
        if (fail_now) begin
            m_fifo.delete(); m_bits.delete(); m_pair = -1; m_fail = 1;
        end
`ifdef TRNG_HEALTH_EN
        else if (clr) begin
            m_fail = 0; m_run = 0;
        end
`endif
    endtask

    task automatic step(bit r, bit en, bit b, bit md, bit rdy, bit clr);
        rst = r; enable = en; raw_bit = b; mode = md;
        out_if.out_ready = rdy; health_clr = clr;
        @(posedge clk);
        model_edge(r, en, b, md, rdy, clr);
        #1;
        chk("level", 32'(out_if.level), 32'(m_fifo.size()));
        chk("out_valid", 32'(out_if.out_valid), 32'(m_fifo.size() > 0));
        chk("out_data", 32'(out_if.out_data), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
        chk("health_fail", 32'(health_fail), 32'(m_fail));
    endtask

    task automatic raw_byte(logic [7:0] v, bit md, bit rdy_last);
        for (int i = 7; i >= 0; i--) step(0, 1, v[i], md, (i == 0) ? rdy_last : 1'b0, 0);
    endtask

    task automatic rnd_bit(output bit b);
        b = 1'($urandom_range(0, 1));
        if (r_same >= 6 && int'(b) == r_last) b = ~b;
        r_same = (int'(b) == r_last) ? r_same + 1 : 1;
        r_last = int'(b);
    endtask

    initial begin
        bit b, md;
        rst = 1; enable = 0; raw_bit = 0; mode = 0; health_clr = 0; out_if.out_ready = 0;

        phase = "reset";
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_level", 32'(out_if.level), 0);
        chk("rst_valid", 32'(out_if.out_valid), 0);
        chk("rst_data", 32'(out_if.out_data), 0);
        chk("rst_health", 32'(health_fail), 0);

        phase = "raw_aa";
        raw_byte(8'hAA, 0, 0);
        chk("aa_word", 32'(out_if.out_data), 32'h0000_00AA);
        step(0, 0, 0, 0, 1, 0);

        phase = "vn_ff";
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 1, 0, 0);
            step(0, 1, 1, 1, 0, 0);
        end
        step(0, 1, 0, 1, 0, 0);
        chk("ff_not_yet", 32'(out_if.out_valid), 0);
        step(0, 1, 1, 1, 0, 0);
        chk("ff_word", 32'(out_if.out_data), 32'h0000_00FF);
        chk("ff_valid", 32'(out_if.out_valid), 1);
        step(0, 0, 0, 1, 1, 0);

        phase = "vn_discard";
        for (int i = 0; i < 8; i++) begin
            step(0, 1, i[0], 1, 0, 0);
            step(0, 1, i[0], 1, 0, 0);
            step(0, 1, 1, 1, 0, 0);
            step(0, 1, 0, 1, 0, 0);
        end
        chk("vn00_level", 32'(out_if.level), 1);
        chk("vn00_word", 32'(out_if.out_data), 0);
        step(0, 0, 0, 1, 1, 0);

        phase = "mode_toggle";
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        raw_byte(8'h5A, 0, 0);
        chk("toggle_level", 32'(out_if.level), 1);
        chk("toggle_word", 32'(out_if.out_data), 32'h0000_005A);
        step(0, 0, 0, 0, 1, 0);

        phase = "fill";
        for (int i = 0; i < 40; i++) begin rnd_bit(b); step(0, 1, b, 0, 0, 0); end
        chk("full_level", 32'(out_if.level), DEPTH);
        step(0, 0, 0, 0, 1, 0);
        chk("one_pop_level", 32'(out_if.level), DEPTH - 1);
        for (int i = 0; i < 10; i++) begin rnd_bit(b); step(0, 1, b, 0, 0, 0); end
        chk("refill_level", 32'(out_if.level), DEPTH);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 0);

        phase = "push_pop";
        raw_byte(8'h3C, 0, 0);
        raw_byte(8'hC5, 0, 0);
        raw_byte(8'h96, 0, 1);
        chk("pp_level", 32'(out_if.level), 2);
        chk("pp_head", 32'(out_if.out_data), 32'h0000_00C5);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        phase = "rst_mid";
        raw_byte(8'h69, 0, 0);
        raw_byte(8'h1E, 0, 0);
        for (int i = 0; i < 5; i++) begin rnd_bit(b); step(0, 1, b, 0, 0, 0); end
        step(1, 0, 0, 0, 0, 0);
        chk("rm_level", 32'(out_if.level), 0);
        chk("rm_valid", 32'(out_if.out_valid), 0);
        chk("rm_data", 32'(out_if.out_data), 0);
        for (int i = 0; i < 7; i++) begin rnd_bit(b); step(0, 1, b, 0, 0, 0); end
        chk("rm_seven", 32'(out_if.level), 0);
        rnd_bit(b); step(0, 1, b, 0, 0, 0);
        chk("rm_eight", 32'(out_if.level), 1);

        phase = "random";
        md = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 5) md = ~md;
            rnd_bit(b);
            step(0, $urandom_range(0, 99) < 80, b, md,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 5);
        end

        phase = "health";
        step(1, 0, 0, 0, 0, 0);
`ifdef TRNG_HEALTH_EN
        for (int i = 0; i < RCT_LIMIT - 1; i++) step(0, 1, 1, 0, 0, 0);
        chk("hf_before", 32'(health_fail), 0);
        chk("hf_before_level", 32'(out_if.level), 1);
        step(0, 1, 1, 0, 0, 0);
        chk("hf_set", 32'(health_fail), 1);
        chk("hf_level", 32'(out_if.level), 0);
        chk("hf_valid", 32'(out_if.out_valid), 0);
        step(0, 1, 0, 0, 0, 1);
        chk("hf_clr", 32'(health_fail), 0);
        raw_byte(8'h5A, 0, 0);
        chk("hf_resume_level", 32'(out_if.level), 1);
        chk("hf_resume_word", 32'(out_if.out_data), 32'h0000_005A);
`else
        for (int i = 0; i < RCT_LIMIT + 4; i++) step(0, 1, 1, 0, 0, 1);
        chk("hf_tied", 32'(health_fail), 0);
        chk("hf_nohealth_level", 32'(out_if.level), 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
